sdnet_to_mtpsa: RTL and testbench

Egress-side adapter for the SDNet suIngress pipeline output, the reverse of the SUME-to-SDNet tuple conversion on the input side. It captures the per-packet SDNet output tuples (mtpsa metadata and digest) into a small tuple FIFO. It re-attaches each tuple to the matching SDNet output packet as SUME m_axis_tuser, held on every beat of that packet. The output is registered and drives the downstream output queues.

---
 rtl/sdnet_to_mtpsa.sv | 149 ++++++++++++++
 tb/tb_sdnet_to_mtpsa.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdnet_to_mtpsa.sv
// sdnet_to_mtpsa: egress adapter that queues the SDNet metadata/digest tuples
// and re-attaches them as m_axis_tuser on every beat of the matching packet.
// Optional statistics outputs are enabled by defining SDNET_TO_MTPSA_STATS_EN.
module sdnet_to_mtpsa #(
  parameter int C_AXIS_DATA_WIDTH    = 256,
  parameter int META_WIDTH           = 128,
  parameter int META_KEEP            = 48,
  parameter int DIGEST_WIDTH         = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 304,
  parameter int TUPLE_FIFO_DEPTH     = 4
) (
  input  logic                              axis_aclk,
  input  logic                              axis_resetn,
  input  logic [C_AXIS_DATA_WIDTH-1:0]      s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]    s_axis_tkeep,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic                              s_axis_tlast,
  input  logic                              meta_tuple_valid,
  input  logic [META_WIDTH-1:0]             meta_tuple_data,
  input  logic                              digest_tuple_valid,
  input  logic [DIGEST_WIDTH-1:0]           digest_tuple_data,
  output logic [C_AXIS_DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic                              tuple_overflow
`ifdef SDNET_TO_MTPSA_STATS_EN
  ,
  output logic [31:0]                       stat_pkt_count,
  output logic [15:0]                       stat_drop_count
`endif
);

  localparam int unsigned TUPLE_W = DIGEST_WIDTH + META_KEEP;
  localparam int unsigned PTR_W   = (TUPLE_FIFO_DEPTH > 1) ? $clog2(TUPLE_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic {
    SOP,
    BODY
  } state_t;

  state_t state, state_next;

  logic [TUPLE_W-1:0]      fifo_mem [TUPLE_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    fifo_not_empty;
  logic [TUPLE_W-1:0]      fifo_head;
  logic [DIGEST_WIDTH-1:0] digest_sel;
  logic [TUPLE_W-1:0]      new_tuple;
  logic                    in_hs;
  logic                    pop;
  logic                    push_ok;
  logic                    drop;
  logic                    unused_meta;

  // Tuple formation and FIFO push/drop decision
  always_comb begin
    digest_sel     = digest_tuple_valid ? digest_tuple_data : '0;
    new_tuple      = {digest_sel, meta_tuple_data[META_KEEP-1:0]};
    fifo_not_empty = (count != '0);
    fifo_head      = fifo_mem[rd_ptr];
    push_ok        = meta_tuple_valid && ((count < CNT_W'(TUPLE_FIFO_DEPTH)) || pop);
    drop           = meta_tuple_valid && !push_ok;
    unused_meta    = ^meta_tuple_data[META_WIDTH-1:META_KEEP];
  end

  // Packet-boundary FSM, input ready and handshake decode
  always_comb begin
    state_next    = state;
    s_axis_tready = (!m_axis_tvalid || m_axis_tready) && ((state == BODY) || fifo_not_empty);
    in_hs         = s_axis_tvalid && s_axis_tready;
    pop           = in_hs && s_axis_tlast;
    case (state)
      SOP:     if (in_hs && !s_axis_tlast) state_next = BODY;
      BODY:    if (pop) state_next = SOP;
      default: state_next = SOP;
    endcase
  end

  // FSM state register
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) state <= SOP;
    else              state <= state_next;
  end

  // Tuple storage; written only on an accepted push, read via rd_ptr next cycle onward
  always_ff @(posedge axis_aclk) begin
    if (push_ok) fifo_mem[wr_ptr] <= new_tuple;
  end

  // FIFO pointers, occupancy and overflow pulse
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      tuple_overflow <= 1'b0;
    end else begin
      tuple_overflow <= drop;
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered output stage: load on input handshake, hold while stalled
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (in_hs) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tkeep  <= s_axis_tkeep;
      m_axis_tuser  <= C_M_AXIS_TUSER_WIDTH'(fifo_head);
      m_axis_tlast  <= s_axis_tlast;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

`ifdef SDNET_TO_MTPSA_STATS_EN
  // Packet counter (wrapping) and drop counter (saturating)
  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      stat_pkt_count  <= '0;
      stat_drop_count <= '0;
    end else begin
      if (m_axis_tvalid && m_axis_tready && m_axis_tlast)
        stat_pkt_count <= stat_pkt_count + 32'd1;
      if (drop && (stat_drop_count != '1))
        stat_drop_count <= stat_drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdnet_to_mtpsa.sv
// Self-checking bench for sdnet_to_mtpsa: randomized traffic plus directed
// scenarios, compared against a transaction-level model (tuple queue + output slot).
module tb_sdnet_to_mtpsa;

  logic          axis_aclk;
  logic          axis_resetn;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic          meta_tuple_valid;
  logic [127:0]  meta_tuple_data;
  logic          digest_tuple_valid;
  logic [255:0]  digest_tuple_data;
  logic [255:0]  m_axis_tdata;
  logic [31:0]   m_axis_tkeep;
  logic [303:0]  m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic          tuple_overflow;

  sdnet_to_mtpsa #(
    .C_AXIS_DATA_WIDTH    (256),
    .META_WIDTH           (128),
    .META_KEEP            (48),
    .DIGEST_WIDTH         (256),
    .C_M_AXIS_TUSER_WIDTH (304),
    .TUPLE_FIFO_DEPTH     (4)
  ) dut (
    .axis_aclk          (axis_aclk),
    .axis_resetn        (axis_resetn),
    .s_axis_tdata       (s_axis_tdata),
    .s_axis_tkeep       (s_axis_tkeep),
    .s_axis_tvalid      (s_axis_tvalid),
    .s_axis_tready      (s_axis_tready),
    .s_axis_tlast       (s_axis_tlast),
    .meta_tuple_valid   (meta_tuple_valid),
    .meta_tuple_data    (meta_tuple_data),
    .digest_tuple_valid (digest_tuple_valid),
    .digest_tuple_data  (digest_tuple_data),
    .m_axis_tdata       (m_axis_tdata),
    .m_axis_tkeep       (m_axis_tkeep),
    .m_axis_tuser       (m_axis_tuser),
    .m_axis_tvalid      (m_axis_tvalid),
    .m_axis_tready      (m_axis_tready),
    .m_axis_tlast       (m_axis_tlast),
    .tuple_overflow     (tuple_overflow)
  );

  initial axis_aclk = 1'b0;
  always #5 axis_aclk = ~axis_aclk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: queued tuples, one output slot, packet-in-progress flag
  logic [303:0] tq [$];
  logic         mv;
  logic [255:0] md;
  logic [31:0]  mk;
  logic         ml;
  logic [303:0] mu;
  logic         ovf;
  logic         in_body;
  bit           hs;

  task automatic check_eq(input string tag, input logic [303:0] obs, input logic [303:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r = {r[223:0], $urandom()};
    return r;
  endfunction

  task automatic clear_model();
    tq.delete();
    mv = 1'b0; md = '0; mk = '0; ml = 1'b0; mu = '0;
    ovf = 1'b0; in_body = 1'b0; hs = 1'b0;
  endtask

  // One clock: check DUT against model at negedge, then advance model
  task automatic cycle();
    logic         exp_ready;
    logic         pop;
    logic [303:0] tup;
    bit           acc;
    @(negedge axis_aclk);
    exp_ready = (!mv || m_axis_tready) && (in_body || tq.size() != 0);
    check_eq("s_tready", s_axis_tready, exp_ready);
    check_eq("m_tvalid", m_axis_tvalid, mv);
    if (mv) begin
      check_eq("m_tdata", m_axis_tdata, md);
      check_eq("m_tkeep", m_axis_tkeep, mk);
      check_eq("m_tuser", m_axis_tuser, mu);
      check_eq("m_tlast", m_axis_tlast, ml);
    end
    check_eq("overflow", tuple_overflow, ovf);
    hs  = s_axis_tvalid && exp_ready && axis_resetn;
    pop = hs && s_axis_tlast;
    if (hs) begin
      mv = 1'b1; md = s_axis_tdata; mk = s_axis_tkeep; ml = s_axis_tlast;
      mu = tq[0];
      in_body = !s_axis_tlast;
    end else if (m_axis_tready) begin
      mv = 1'b0;
    end
    ovf = 1'b0;
    acc = (tq.size() < 4) || pop;
    if (pop) void'(tq.pop_front());
    if (meta_tuple_valid && axis_resetn) begin
      tup = '0;
      tup[47:0] = meta_tuple_data[47:0];
      if (digest_tuple_valid) tup[303:48] = digest_tuple_data;
      if (acc) tq.push_back(tup);
      else     ovf = 1'b1;
    end
    if (!axis_resetn) clear_model();
    @(posedge axis_aclk);
    #1;
  endtask

  task automatic do_reset();
    axis_resetn = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    meta_tuple_valid = 1'b0; digest_tuple_valid = 1'b0;
    m_axis_tready = 1'b1;
    #1;
    check_eq("rst_tvalid", m_axis_tvalid, 1'b0);
    check_eq("rst_tdata", m_axis_tdata, '0);
    check_eq("rst_tuser", m_axis_tuser, '0);
    check_eq("rst_tlast", m_axis_tlast, 1'b0);
    check_eq("rst_ovf", tuple_overflow, 1'b0);
    clear_model();
    cycle();
    cycle();
    axis_resetn = 1'b1;
  endtask

  task automatic push_tuple(input logic [47:0] m, input logic [255:0] d, input logic dv);
    meta_tuple_valid   = 1'b1;
    meta_tuple_data    = {$urandom(), $urandom(), 16'($urandom()), m};
    digest_tuple_valid = dv;
    digest_tuple_data  = d;
    cycle();
    meta_tuple_valid   = 1'b0;
    digest_tuple_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    for (int i = 0; i < n; i++) cycle();
  endtask

  // rmode: 0 always ready, 1 random ready + random tuples, 2 ready pattern 1,0,0,1
  task automatic send_pkt(input int nb, input int tuple_at, input int rmode);
    int t;
    int n;
    t = 0;
    for (int b = 0; b < nb; b++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = rand256();
      s_axis_tkeep  = $urandom();
      s_axis_tlast  = (b == nb - 1);
      n = 0;
      do begin
        case (rmode)
          0:       m_axis_tready = 1'b1;
          1:       m_axis_tready = ($urandom_range(0, 3) != 0);
          default: m_axis_tready = ((t % 4) == 0) || ((t % 4) == 3);
        endcase
        meta_tuple_valid = (t == tuple_at) || (rmode == 1 && $urandom_range(0, 7) == 0);
        if (meta_tuple_valid) begin
          meta_tuple_data    = {$urandom(), $urandom(), $urandom(), $urandom()};
          digest_tuple_valid = $urandom_range(0, 1) != 0;
          digest_tuple_data  = rand256();
        end
        cycle();
        meta_tuple_valid   = 1'b0;
        digest_tuple_valid = 1'b0;
        t++;
        n++;
      end while (!hs && n < 300);
      if (!hs) begin
        check_eq("beat_timeout", hs, 1'b1);
        s_axis_tvalid = 1'b0;
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  initial begin
    int ta;
    axis_resetn = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    meta_tuple_valid = 1'b0; meta_tuple_data = '0;
    digest_tuple_valid = 1'b0; digest_tuple_data = '0;
    m_axis_tready = 1'b1;
    do_reset();

    // Single 2-beat packet with a known tuple
    push_tuple(48'h010004010040, {32{8'hA5}}, 1'b1);
    send_pkt(2, -1, 0);
    idle(2);

    // Packet presented before its tuple arrives
    send_pkt(3, 5, 0);
    idle(3);

    // Overflow: five tuples into a four-deep queue, then four one-beat packets
    for (int i = 0; i < 5; i++) push_tuple(48'h1000 + 48'(i), rand256(), 1'b1);
    idle(2);
    for (int i = 0; i < 4; i++) send_pkt(1, -1, 0);
    idle(3);

    // Backpressure during a 4-beat packet
    push_tuple(48'hBEEF0000CAFE, rand256(), 1'b1);
    send_pkt(4, -1, 2);
    idle(3);

    // Metadata without digest, then a stray digest strobe alone
    push_tuple(48'h0000_1234_5678, rand256(), 1'b0);
    send_pkt(1, -1, 0);
    digest_tuple_valid = 1'b1;
    digest_tuple_data  = rand256();
    cycle();
    digest_tuple_valid = 1'b0;
    idle(2);

    // Reset in the middle of a 4-beat packet with two tuples queued
    push_tuple(48'h111111111111, rand256(), 1'b1);
    push_tuple(48'h222222222222, rand256(), 1'b1);
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tlast  = 1'b0;
    for (int b = 0; b < 2; b++) begin
      s_axis_tdata = rand256();
      s_axis_tkeep = $urandom();
      cycle();
      check_eq("midpkt_hs", hs, 1'b1);
    end
    do_reset();
    push_tuple(48'h333333333333, rand256(), 1'b1);
    send_pkt(1, -1, 0);
    idle(3);

    // Randomized traffic
    for (int p = 0; p < 40; p++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--)
        push_tuple(48'($urandom()) << 16 | 48'($urandom_range(0, 65535)), rand256(),
                   $urandom_range(0, 1) != 0);
      ta = (tq.size() == 0) ? $urandom_range(0, 3) : -1;
      send_pkt($urandom_range(1, 5), ta, 1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
